// File: rtl/bus_handshake.sv
// Purpose: fully registered valid/ready slice (skid buffer) between an upstream producer and a downstream consumer.
// Latency: one cycle from upstream acceptance to the word appearing on valid_src/data_src.
// Backpressure: a skid register absorbs one word when ready_src drops; ready_dnt is registered and falls only when the skid is full.
module bus_handshake #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_dnt,
    input  logic [WIDTH-1:0] data_dnt,
    output logic             ready_dnt,
    output logic             valid_src,
    output logic [WIDTH-1:0] data_src,
    input  logic             ready_src
);

    // EMPTY: no word held, ONE: output register full, FULL: output and skid full
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    logic up_xfer;
    logic dn_xfer;

    // Transfer qualifiers; ready_dnt comes straight from a flop, so no input reaches an output
    assign up_xfer   = valid_dnt & ready_dnt;
    assign dn_xfer   = out_valid & ready_src;

    assign ready_dnt = ~skid_valid;
    assign valid_src = out_valid;
    assign data_src  = out_data;

    // Slice state machine: data registers load only on an accepted transfer, reset discards everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_xfer) begin
                        out_data  <= data_dnt;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (dn_xfer && up_xfer) begin
                        // pass-through: the departing word is replaced in place
                        out_data <= data_dnt;
                    end else if (dn_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (up_xfer) begin
                        // consumer stalled: park the new word behind the output
                        skid_data  <= data_dnt;
                        skid_valid <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    // upstream is blocked here, so only a downstream transfer moves anything
                    if (dn_xfer) begin
                        out_data   <= skid_data;
                        skid_valid <= 1'b0;
                        state      <= ONE;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    out_valid  <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_handshake.sv
// Purpose: scoreboard bench for bus_handshake; stimulus pushes accepted words, a monitor pops on every output transfer.
// Latency: inputs change 1 ns after a rising edge, everything is sampled on the falling edge.
// Backpressure: directed stalls plus a random valid/ready phase, then a drain.
module tb_bus_handshake;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_dnt;
    logic [WIDTH-1:0] data_dnt;
    logic             ready_dnt;
    logic             valid_src;
    logic [WIDTH-1:0] data_src;
    logic             ready_src;

    int checks = 0;
    int passes = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    bus_handshake #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_dnt (valid_dnt),
        .data_dnt  (data_dnt),
        .ready_dnt (ready_dnt),
        .valid_src (valid_src),
        .data_src  (data_src),
        .ready_src (ready_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One cycle of upstream stimulus; exp_rdy/exp_vld of -1 means "not checked this cycle"
    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r,
                         input int exp_rdy, input int exp_vld);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        valid_dnt = v;
        data_dnt  = d;
        ready_src = r;
        @(negedge clk);
        if (exp_rdy >= 0) chk("ready_dnt", {31'd0, ready_dnt}, exp_rdy[WIDTH-1:0]);
        if (exp_vld >= 0) chk("valid_src", {31'd0, valid_src}, exp_vld[WIDTH-1:0]);
        if (valid_dnt && ready_dnt) exp_q.push_back(data_dnt);
    endtask

    // Monitor: pop and compare on every downstream transfer, and check stall stability
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, valid_src}, 32'd1);
                chk("stall_data", data_src, prev_data);
            end
            if (valid_src && ready_src) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", data_src, 32'hDEAD_BEEF);
                end else begin
                    chk("data_order", data_src, exp_q.pop_front());
                end
            end
            prev_stall = valid_src && !ready_src;
            prev_data  = data_src;
        end
    end

    initial begin
        rst       = 1'b1;
        valid_dnt = 1'b1;
        data_dnt  = 32'h1;
        ready_src = 1'b1;

        // reset held for two edges with a word offered
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rst_valid_src", {31'd0, valid_src}, 32'd0);
            chk("rst_data_src", data_src, 32'd0);
            chk("rst_ready_dnt", {31'd0, ready_dnt}, 32'd1);
        end

        // streaming
        drive(1'b1, 32'h3, 1'b1, 1, 0);
        drive(1'b1, 32'h4, 1'b1, 1, 1);
        drive(1'b1, 32'h5, 1'b1, 1, 1);
        drive(1'b1, 32'h6, 1'b1, 1, 1);
        drive(1'b1, 32'h7, 1'b1, 1, 1);
        drive(1'b1, 32'h8, 1'b1, 1, 1);

        // single-cycle backpressure; 0x11 is refused once and re-offered
        drive(1'b1, 32'h9,  1'b1, 1, 1);
        drive(1'b1, 32'h10, 1'b0, 1, 1);
        drive(1'b1, 32'h11, 1'b1, 0, 1);
        drive(1'b1, 32'h11, 1'b1, 1, 1);

        // long stall: 0x11 in output, 0x12 in skid, later offers ignored
        drive(1'b1, 32'h12, 1'b0, 1, 1);
        drive(1'b1, 32'h13, 1'b0, 0, 1);
        drive(1'b1, 32'h14, 1'b0, 0, 1);
        drive(1'b1, 32'h15, 1'b0, 0, 1);
        drive(1'b1, 32'h13, 1'b1, 0, 1);
        drive(1'b1, 32'h13, 1'b1, 1, 1);
        drive(1'b1, 32'h14, 1'b1, 1, 1);

        // one-cycle bubble with zero data
        drive(1'b0, 32'h0,  1'b1, 1, 1);
        drive(1'b1, 32'h15, 1'b1, 1, 0);
        drive(1'b1, 32'h16, 1'b1, 1, 1);
        drive(1'b0, 32'h0,  1'b1, 1, 1);

        // random valid/ready
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), -1, -1);
        end

        // drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, -1, -1);
        end
        chk("final_valid_src", {31'd0, valid_src}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
